uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_fifo.sv | 61 ++++++
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit (and later receive) path.
//   uart_state_t    : frame FSM state (IDLE, START, DATA, STOP)
//   UART_DATA_BITS  : data bits per frame
//   UART_FRAME_BITS : start + data + stop bits per frame
//   frame_cycles()  : clock cycles in one frame for a given clocks-per-bit
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = UART_DATA_BITS + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int frame_cycles(input int clks_per_bit);
    return UART_FRAME_BITS * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO used to buffer UART bytes.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write din when push and not full
//   pop/dout : dout is the head entry; pop advances it when not empty
//   full, empty, count : occupancy, all derived from the registered count
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Requests that cannot be honoured are dropped here, so callers never
  // corrupt the pointers even if they ignore full/empty.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter.
//   CLK, RST : clock, synchronous active-high reset
//   wr_valid, wr_data, wr_ready : byte write channel; a byte is taken on a
//     rising edge where wr_valid && wr_ready (valid may be held, data must
//     stay stable while valid is high and ready is low; ready never depends
//     on valid)
//   tx    : registered serial output, idle high, LSB first
//   busy  : a frame is in flight or bytes are still queued
//   state : current frame FSM state, exported for observation
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        tx,
  output logic        busy,
  output uart_state_t state
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(UART_DATA_BITS - 1);

  uart_state_t               state_next;
  logic [BW-1:0]             baud_cnt, baud_next;
  logic [IW-1:0]             bit_idx, bit_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic                      tx_next;
  logic                      bit_end;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic [7:0]                fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // Ready comes only from registered occupancy (and reset), so a pop in a
  // full cycle frees the slot one cycle later.
  assign wr_ready  = !RST && !fifo_full;
  assign fifo_push = wr_valid && wr_ready;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (fifo_push),
    .din   (wr_data),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign busy    = (state != IDLE) || (fifo_count != '0);

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    fifo_pop   = 1'b0;
    tx_next    = 1'b1;

    case (state)
      IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          state_next = START;
          fifo_pop   = 1'b1;
          shift_next = fifo_head;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bit_next   = bit_idx + 1'b1;
            shift_next = shift_reg >> 1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_next = '0;
          // Chain straight into the next start bit so queued bytes go out
          // with no idle gap.
          if (!fifo_empty) begin
            state_next = START;
            fifo_pop   = 1'b1;
            shift_next = fifo_head;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // tx is registered, so it is computed from where the FSM is going.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
      tx        <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Three instances share clock and reset:
// index 0 (CLKS_PER_BIT=4) for directed tests, 1 (=2) and 2 (=16) for
// random stress. A line decoder watches the active instance's tx pin.
module tb_uart_tx;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wv  [3];
  logic [7:0]  wd  [3];
  logic        wr  [3];
  logic        txs [3];
  logic        bz  [3];
  uart_state_t st  [3];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_a (
    .CLK(clk), .RST(rst), .wr_valid(wv[0]), .wr_data(wd[0]),
    .wr_ready(wr[0]), .tx(txs[0]), .busy(bz[0]), .state(st[0]));

  uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut_b (
    .CLK(clk), .RST(rst), .wr_valid(wv[1]), .wr_data(wd[1]),
    .wr_ready(wr[1]), .tx(txs[1]), .busy(bz[1]), .state(st[1]));

  uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut_c (
    .CLK(clk), .RST(rst), .wr_valid(wv[2]), .wr_data(wd[2]),
    .wr_ready(wr[2]), .tx(txs[2]), .busy(bz[2]), .state(st[2]));

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q [$];
  int unsigned starts [$];
  int          act = 0;

  function automatic int cpb_of(input int k);
    case (k)
      0:       return 4;
      1:       return 2;
      default: return 16;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- line decoder ----------------
  // Samples every cycle of a frame: the first cycle of each bit gives its
  // value, every later cycle of that bit must match it.
  logic       prev_tx = 1'b1;
  logic [9:0] dbits;
  logic       d_ok, d_abort, d_v;
  int         d_cpb, d_c;

  always begin
    @(negedge clk);
    if (!rst && prev_tx && !txs[act]) begin
      d_cpb = cpb_of(act);
      starts.push_back(cyc);
      dbits = '1;
      dbits[0] = 1'b0;
      d_ok = 1'b1;
      d_abort = 1'b0;
      d_c = 1;
      while (d_c < 10 * d_cpb && !d_abort) begin
        @(negedge clk);
        if (rst) begin
          d_abort = 1'b1;
        end else begin
          d_v = txs[act];
          if (d_c % d_cpb == 0) dbits[d_c / d_cpb] = d_v;
          else if (d_v !== dbits[d_c / d_cpb]) d_ok = 1'b0;
        end
        d_c++;
      end
      if (!d_abort) begin
        check("frame_shape", {30'd0, d_ok, dbits[9]}, 32'd3);
        check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("rx_byte", {24'd0, dbits[8:1]}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_tx = rst ? 1'b1 : txs[act];
  end

  // ---------------- driver tasks ----------------
  // Called just after a negedge; returns just after the negedge that
  // follows the accepting posedge, with acc = that edge's number.
  task automatic send(input int k, input logic [7:0] b, output int unsigned acc);
    int   t = 0;
    logic done = 1'b0;
    acc = 0;
    wd[k] = b;
    wv[k] = 1'b1;
    while (!done) begin
      if (wr[k]) begin
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        exp_q.push_back(b);
        done = 1'b1;
      end else begin
        @(negedge clk);
        t++;
        if (t > 2000) begin
          check("accept_timeout", {31'd0, wr[k]}, 32'd1);
          done = 1'b1;
        end
      end
    end
    wv[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int t = 0;
    while ((bz[k] || exp_q.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check("idle_timeout", {31'd0, bz[k]}, 32'd0);
  endtask

  task automatic wait_start(input int n0);
    int t = 0;
    while (starts.size() <= n0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      $display("FAIL start_timeout: got no start bit, expected one");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "no start bit");
    end
  endtask

  // ---------------- stimulus ----------------
  int unsigned a0, a1, a2, edge_n;
  int unsigned accs [6];
  int          n0, t;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wv[k] = 1'b0;
      wd[k] = 8'h00;
    end
    wv[0] = 1'b1;
    wd[0] = 8'h99;

    // Reset held 3 cycles with a byte offered: nothing may be taken.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_tx", {31'd0, txs[0]}, 32'd1);
      check("reset_busy", {31'd0, bz[0]}, 32'd0);
      check("reset_ready", {31'd0, wr[0]}, 32'd0);
      check("reset_state", {30'd0, st[0]}, {30'd0, IDLE});
    end
    rst = 1'b0;
    wv[0] = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, wr[0]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("nothing_accepted", {31'd0, bz[0]}, 32'd0);

    // Single byte 0x55: tx falls one edge after acceptance, busy clears
    // exactly 40 cycles after the start edge.
    n0 = starts.size();
    send(0, 8'h55, a0);
    check("tx_before_start", {31'd0, txs[0]}, 32'd1);
    check("busy_queued", {31'd0, bz[0]}, 32'd1);
    wait_start(n0);
    check("start_latency", starts[n0] - a0, 32'd1);
    t = 0;
    while (bz[0] && t < 200) begin
      @(negedge clk);
      t++;
    end
    edge_n = cyc;
    check("busy_drop", edge_n - starts[n0], 32'd40);
    check("idle_state", {30'd0, st[0]}, {30'd0, IDLE});

    // Burst 0x41..0x46: five taken on consecutive edges, the sixth only
    // after the full-and-pop cycle at the end of 0x41's frame.
    repeat (3) @(negedge clk);
    n0 = starts.size();
    for (int i = 0; i < 6; i++) send(0, 8'(8'h41 + i), accs[i]);
    for (int i = 1; i < 5; i++) check("burst_accept", accs[i] - accs[0], i);
    check("full_pop_accept", accs[5] - accs[0], 32'd42);
    wait_idle(0);
    check("burst_frames", starts.size() - n0, 32'd6);
    check("burst_first_start", starts[n0] - accs[0], 32'd1);
    for (int i = 1; i < 6; i++) check("b2b_spacing", starts[n0 + i] - starts[n0 + i - 1], 32'd40);

    // Reset in data bit 3 of 0xA3 with two bytes queued.
    repeat (2) @(negedge clk);
    n0 = starts.size();
    send(0, 8'hA3, a0);
    send(0, 8'hB1, a1);
    send(0, 8'hB2, a2);
    wait_start(n0);
    t = 0;
    while (cyc < starts[n0] + 17 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("mid_bit3_tx", {31'd0, txs[0]}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_tx", {31'd0, txs[0]}, 32'd1);
    check("midreset_busy", {31'd0, bz[0]}, 32'd0);
    check("midreset_state", {30'd0, st[0]}, {30'd0, IDLE});
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    send(0, 8'h0F, a0);
    wait_idle(0);
    repeat (50) @(negedge clk);
    check("post_reset_frames", starts.size() - n0, 32'd2);

    // Random stress on the fast and slow instances.
    for (int k = 1; k < 3; k++) begin
      act = k;
      n0 = starts.size();
      for (int i = 0; i < (k == 1 ? 1000 : 300); i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(k, 8'($urandom_range(0, 255)), a0);
      end
      wait_idle(k);
      check("stress_frames", starts.size() - n0, (k == 1) ? 32'd1000 : 32'd300);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
